// File: rtl/ram_writer_pkg.sv
// Shared definitions for the RAM write-side controller: default widths and FSM state encoding.
// Optional readback verification is enabled by defining VERIFY_EN.
package ram_writer_pkg;

  localparam int ADDR_W_DEF = 2;
  localparam int DATA_W_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic state_busy(input state_t st);
    return (st != ST_IDLE);
  endfunction

endpackage

// File: rtl/ram_writer_addr_counter.sv
// Loadable, wrapping write-address counter for ram_writer; its count drives mem_addr directly.
module addr_counter
  import ram_writer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] count
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] count_r;

  // Load has priority over increment; natural overflow gives the DEPTH-1 -> 0 wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {ADDR_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (inc) begin
      count_r <= count_r + ADDR_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/ram_writer.sv
// Write-side RAM controller: streams a burst of host words into consecutive wrapping addresses.
// Define VERIFY_EN to add a readback CHECK state after every write and a sticky err flag.
module ram_writer
  import ram_writer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] REM_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_r;
  state_t            next_state_s;
  logic [ADDR_W:0]   remaining_r;
  logic [DATA_W-1:0] wdata_r;
  logic              in_ready_r;
  logic              mem_we_r;
  logic              busy_r;
  logic              done_r;
  logic              in_ready_nx_s;
  logic              mem_we_nx_s;
  logic              busy_nx_s;
  logic              done_nx_s;
  logic              accept_start_s;
  logic              handshake_s;
  logic              addr_inc_s;

  assign accept_start_s = (state_r == ST_IDLE) && start;
  assign handshake_s    = in_ready_r && in_valid;

  // With verification the address must stay on the written word through CHECK
`ifdef VERIFY_EN
  assign addr_inc_s = (state_r == ST_CHECK);
`else
  assign addr_inc_s = (state_r == ST_WRITE);
`endif

  addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_addr_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept_start_s),
    .inc      (addr_inc_s),
    .load_val (base_addr),
    .count    (mem_addr)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = (len == REM_ZERO) ? ST_DONE : ST_LOAD;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (handshake_s) begin
          next_state_s = ST_WRITE;
        end else begin
          next_state_s = ST_LOAD;
        end
      end
      ST_WRITE: begin
`ifdef VERIFY_EN
        next_state_s = ST_CHECK;
`else
        next_state_s = (remaining_r == REM_ONE) ? ST_DONE : ST_LOAD;
`endif
      end
      ST_CHECK: begin
`ifdef VERIFY_EN
        // remaining was already decremented in WRITE
        next_state_s = (remaining_r == REM_ZERO) ? ST_DONE : ST_LOAD;
`else
        next_state_s = ST_IDLE;
`endif
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // FSM output decode from the upcoming state so the registered outputs line up with it
  always_comb begin
    in_ready_nx_s = (next_state_s == ST_LOAD);
    mem_we_nx_s   = (next_state_s == ST_WRITE);
    busy_nx_s     = state_busy(next_state_s);
    done_nx_s     = (next_state_s == ST_DONE);
  end

  // Registered status outputs, remaining-word counter and captured host word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_r  <= 1'b0;
      mem_we_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      remaining_r <= REM_ZERO;
      wdata_r     <= {DATA_W{1'b0}};
    end else begin
      in_ready_r <= in_ready_nx_s;
      mem_we_r   <= mem_we_nx_s;
      busy_r     <= busy_nx_s;
      done_r     <= done_nx_s;
      if (accept_start_s) begin
        remaining_r <= len;
      end else if (state_r == ST_WRITE) begin
        remaining_r <= remaining_r - REM_ONE;
      end else begin
        remaining_r <= remaining_r;
      end
      if (handshake_s) begin
        wdata_r <= in_data;
      end else begin
        wdata_r <= wdata_r;
      end
    end
  end

`ifdef VERIFY_EN
  logic err_r;

  // Sticky readback mismatch flag, cleared only by an accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_r <= 1'b0;
    end else if (accept_start_s) begin
      err_r <= 1'b0;
    end else if ((state_r == ST_CHECK) && (mem_rdata != wdata_r)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  logic rdata_unused_s;
  assign rdata_unused_s = ^mem_rdata;
  assign err            = 1'b0;
`endif

  assign in_ready  = in_ready_r;
  assign mem_we    = mem_we_r;
  assign mem_wdata = wdata_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_ram_writer.sv
// Self-checking bench for ram_writer: table vectors, reset-abort sequence and random bursts
// compared against an address/data image model. Define VERIFY_EN to also exercise readback.
module tb_ram_writer;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef VERIFY_EN
  localparam int WPC = 3;
`else
  localparam int WPC = 2;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  ram_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err(err)
  );

  // RAM model with an optional read-path bit error on address 1
  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] exp_mem [DEPTH];
  logic ram_clr = 1'b0;
  logic fault_en = 1'b0;
  always_comb mem_rdata = ram[mem_addr] ^ ((fault_en && mem_addr == 2'd1) ? 2'b01 : 2'b00);
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: record every write and done pulse, and check ready/we never overlap
  int wq_addr[$];
  int wq_data[$];
  int wq_cyc[$];
  int done_q[$];
  always @(negedge clk) begin
    if (reset) begin
      if (mem_we) begin
        wq_addr.push_back(int'(mem_addr));
        wq_data.push_back(int'(mem_wdata));
        wq_cyc.push_back(cyc);
      end
      if (done) done_q.push_back(cyc);
      chk("ready_we_exclusive", {31'd0, in_ready & mem_we}, 32'd0);
    end
  end

  task automatic clear_mon();
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); done_q.delete();
  endtask

  task automatic run_burst(input logic [1:0] b, input logic [2:0] n, input logic [13:0] words,
                           input int gap, input bit busy_start, input bit exp_err);
    int idx, since, budget, start_cyc, a;
    bit hs;
    int hs_cyc[$];
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; len = n;
    @(posedge clk); #1;
    start = 1'b0; base_addr = ~b; len = 3'd1;
    start_cyc = cyc;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("err_cleared_on_start", {31'd0, err}, 32'd0);
    idx = 0; since = 100; budget = 300;
    while (idx < int'(n) && budget > 0) begin
      chk("in_ready_pattern", {31'd0, in_ready}, (since >= WPC) ? 32'd1 : 32'd0);
      in_valid = (since > gap);
      in_data  = words[idx*DATA_W +: DATA_W];
      if (busy_start && idx == 1 && since == 1) begin
        start = 1'b1; base_addr = ~b; len = 3'd2;
      end else begin
        start = 1'b0;
      end
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (hs) begin
        hs_cyc.push_back(cyc); idx++; since = 1;
      end else begin
        since++;
      end
      budget--;
    end
    in_valid = 1'b0;
    if (budget == 0) chk("burst_timeout", 32'd1, 32'd0);
    repeat (WPC + 3) @(posedge clk);
    #1;
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("done_pulses", done_q.size(), 32'd1);
    chk("write_count", wq_addr.size(), int'(n));
    for (int i = 0; i < wq_addr.size() && i < int'(n); i++) begin
      chk("write_addr", wq_addr[i], (int'(b) + i) % DEPTH);
      chk("write_data", wq_data[i], int'(words[i*DATA_W +: DATA_W]));
      if (i < hs_cyc.size()) chk("write_latency", wq_cyc[i], hs_cyc[i]);
    end
    if (done_q.size() > 0) begin
      if (n == 3'd0) chk("done_timing_len0", done_q[0], start_cyc);
      else if (hs_cyc.size() > 0) chk("done_timing", done_q[0], hs_cyc[hs_cyc.size()-1] + WPC - 1);
    end
    chk("err_final", {31'd0, err}, {31'd0, exp_err});
    for (int i = 0; i < int'(n); i++) begin
      a = (int'(b) + i) % DEPTH;
      exp_mem[a] = words[i*DATA_W +: DATA_W];
    end
    for (int i = 0; i < DEPTH; i++) chk("ram_readback", {30'd0, ram[i]}, {30'd0, exp_mem[i]});
  endtask

  typedef struct {
    logic [1:0]  base;
    logic [2:0]  len;
    logic [13:0] words;
    int          gap;
    bit          busy_start;
    int          exp_writes;
    int          exp_last;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, budget;
    bit hs;
    vecs[0] = '{2'd0, 3'd0, 14'h0000, 0, 1'b0, 0, 0};
    vecs[0] = '{2'd0, 3'd4, 14'h0027, 0, 1'b0, 4, 3};
    vecs[1] = '{2'd3, 3'd2, 14'h0009, 0, 1'b0, 2, 0};
    vecs[2] = '{2'd2, 3'd0, 14'h0000, 0, 1'b0, 0, 0};
    vecs[3] = '{2'd1, 3'd3, 14'h001E, 0, 1'b1, 3, 3};
    vecs[4] = '{2'd2, 3'd4, 14'h00E4, 3, 1'b0, 4, 1};
    vecs[5] = '{2'd3, 3'd1, 14'h0002, 1, 1'b0, 1, 3};
    vecs[6] = '{2'd1, 3'd5, 14'h0239, 0, 1'b0, 5, 1};

    reset = 1'b1; start = 1'b0; base_addr = '0; len = '0; in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    #2 reset = 1'b0;
    ram_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ram_clr = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_mem_addr", {30'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {30'd0, mem_wdata}, 32'd0);
    reset = 1'b1;

    for (int v = 0; v < 7; v++) begin
      run_burst(vecs[v].base, vecs[v].len, vecs[v].words, vecs[v].gap, vecs[v].busy_start, 1'b0);
      chk("tbl_writes", wq_addr.size(), vecs[v].exp_writes);
      if (vecs[v].exp_writes > 0 && wq_addr.size() > 0)
        chk("tbl_last_addr", wq_addr[wq_addr.size()-1], vecs[v].exp_last);
    end

    // Reset in the WRITE cycle of the second word
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 2'd0; len = 3'd4;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 2'd1;
    cnt = 0; budget = 50;
    while (cnt < 2 && budget > 0) begin
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) cnt++;
      budget--;
    end
    chk("abort_reached_second_word", cnt, 32'd2);
    chk("abort_we_before_reset", {31'd0, mem_we}, 32'd1);
    #2 reset = 1'b0;
    #1;
    in_valid = 1'b0;
    chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    chk("abort_mem_addr", {30'd0, mem_addr}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done_q.size(), 32'd0);
    ram_clr = 1'b1;
    @(posedge clk); #1;
    ram_clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    run_burst(2'd1, 3'd2, 14'h000B, 0, 1'b0, 1'b0);

    for (int r = 0; r < 30; r++) begin
      run_burst(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 14'($urandom()),
                int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0);
    end

`ifdef VERIFY_EN
    fault_en = 1'b1;
    run_burst(2'd0, 3'd4, 14'h0027, 0, 1'b0, 1'b1);
    fault_en = 1'b0;
    run_burst(2'd2, 3'd0, 14'h0000, 0, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
